iob_bus_arbiter: RTL and testbench

Two-master to one-slave arbiter for the IOb native bus. It lets the CPU instruction bus (master 0) and data bus (master 1) share a single memory or peripheral port. Grants are round-robin, and each transaction is registered. A timeout counter ends any slave access that never responds. It sits between the CPU wrapper and the system interconnect or on-chip RAM.

---
 rtl/iob_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_iob_bus_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_bus_arbiter.sv
// Two-master to one-slave IOb bus arbiter with round-robin grant, registered
// transactions and a slave-response timeout.
module iob_bus_arbiter #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       TIMEOUT_W = 8,
    parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(32'hDEADBEEF)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                timeout,
    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  grant_q, grant_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  flag_q, flag_d;
    logic [DATA_W-1:0]     resp_q, resp_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  pick;

    // Round-robin: on a tie the master that was not granted last time wins.
    assign pick = m1_valid && (!m0_valid || !last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            resp_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            resp_q  <= resp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        resp_d  = resp_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        unique case (state_q)
            StIdle: begin
                if (m0_valid || m1_valid) begin
                    grant_d = pick;
                    last_d  = pick;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    wstrb_d = pick ? m1_wstrb : m0_wstrb;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A response in the terminal-count cycle beats the timeout.
                if (s_ready) begin
                    resp_d  = s_rdata;
                    state_d = StDone;
                end else if (cnt_q == '1) begin
                    resp_d  = ERR_DATA;
                    flag_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            StDone: begin
                flag_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only; no input reaches an output.
    assign s_valid  = (state_q == StBusy);
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;
    assign m0_ready = (state_q == StDone) && !grant_q;
    assign m1_ready = (state_q == StDone) && grant_q;
    assign m0_rdata = m0_ready ? resp_q : '0;
    assign m1_rdata = m1_ready ? resp_q : '0;
    assign timeout  = flag_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Scoreboard bench for iob_bus_arbiter: expected responses are queued at issue
// and compared against each ready pulse; a behavioural slave answers requests.
module tb_iob_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic        timeout, busy;

    iob_bus_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT_W (4),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] d;
        logic        tmo;
        logic        chk_d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Slave model: 0 = never answers, 1 = answers after slave_wait cycles of
    // s_valid, 2 = holds s_ready high regardless of s_valid.
    int          slave_mode = 1;
    int          slave_wait = 1;
    logic        use_fixed  = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    int          wcnt       = 0;

    always @(negedge clk) begin
        if (slave_mode == 2) begin
            s_ready = 1'b1;
            s_rdata = 32'h0BAD0BAD;
            wcnt    = 0;
        end else if (slave_mode == 1 && s_valid) begin
            if (wcnt == slave_wait) begin
                s_ready = 1'b1;
                s_rdata = use_fixed ? fixed_data : (s_addr ^ 32'hC0DE0000);
                wcnt    = 0;
            end else begin
                s_ready = 1'b0;
                wcnt++;
            end
        end else begin
            s_ready = 1'b0;
            wcnt    = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
        $fatal(1);
    end

    task automatic wait_ready(input int limit, output int got_m, output logic [31:0] got_d,
                              output logic got_to, output int lat);
        got_m  = -1;
        got_d  = '0;
        got_to = 1'b0;
        lat    = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            lat++;
            if (m0_ready || m1_ready) begin
                got_m  = (m0_ready && m1_ready) ? 2 : (m1_ready ? 1 : 0);
                got_d  = m1_ready ? m1_rdata : m0_rdata;
                got_to = timeout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        slave_mode = 1; slave_wait = 0; use_fixed = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata,
                 timeout, busy} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: s_valid=%b s_addr=%h m0_ready=%b m1_ready=%b busy=%b timeout=%b, required all 0",
                         s_valid, s_addr, m0_ready, m1_ready, busy, timeout);
            end
        end
    endtask

    // Both masters valid out of reset and held continuously: order 0,1,0,1.
    task automatic test_simultaneous();
        int got_m, lat;
        logic [31:0] got_d;
        logic got_to;
        exp_t e;
        m0_addr = 32'h1000;
        m1_addr = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            e.m = i % 2; e.tmo = 1'b0; e.chk_d = 1'b1;
            e.d = ((i % 2) == 1 ? 32'h2000 : 32'h1000) ^ 32'hC0DE0000;
            sb.push_back(e);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(10, got_m, got_d, got_to, lat);
            if (i == 3) begin
                m0_valid = 1'b0;
                m1_valid = 1'b0;
            end
            e = sb.pop_front();
            checks++;
            if (got_m !== e.m) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got master %0d, required %0d", i, got_m, e.m);
            end
            checks++;
            if (got_d !== e.d) begin
                failures++;
                $display("FAIL rr_rdata[%0d]: got %h, required %h", i, got_d, e.d);
            end
            checks++;
            if (lat !== (i == 0 ? 2 : 3)) begin
                failures++;
                $display("FAIL rr_latency[%0d]: got %0d cycles, required %0d", i, lat,
                         (i == 0 ? 2 : 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int got_m, lat;
        logic [31:0] got_d;
        logic got_to;
        exp_t e;
        slave_wait = 1; use_fixed = 1'b1; fixed_data = 32'h12345678;
        e.m = 0; e.d = 32'h12345678; e.tmo = 1'b0; e.chk_d = 1'b1;
        sb.push_back(e);
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        @(negedge clk);
        checks++;
        if (!s_valid || s_addr !== 32'h100) begin
            failures++;
            $display("FAIL read_s_addr: s_valid=%b s_addr=%h, required 1 and 00000100", s_valid, s_addr);
        end
        wait_ready(10, got_m, got_d, got_to, lat);
        m0_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (got_m !== e.m || got_d !== e.d || got_to !== e.tmo) begin
            failures++;
            $display("FAIL read_resp: master %0d rdata %h timeout %b, required %0d %h %b",
                     got_m, got_d, got_to, e.m, e.d, e.tmo);
        end
        checks++;
        if (lat + 1 !== 3) begin
            failures++;
            $display("FAIL read_latency: got %0d cycles, required 3", lat + 1);
        end
        checks++;
        if (m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL read_other_rdata: m1_rdata=%h, required 0", m1_rdata);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (m0_ready || m1_ready) begin
                failures++;
                $display("FAIL read_single_pulse: m0_ready=%b m1_ready=%b, required 0 0", m0_ready, m1_ready);
            end
        end
    endtask

    task automatic test_write();
        int got_m, lat;
        logic [31:0] got_d;
        logic got_to;
        exp_t e;
        slave_wait = 3; use_fixed = 1'b0;
        e.m = 1; e.d = 32'h0; e.tmo = 1'b0; e.chk_d = 1'b0;
        sb.push_back(e);
        m1_valid = 1'b1; m1_addr = 32'h2004; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (!s_valid || s_addr !== 32'h2004 || s_wdata !== 32'hA5A5A5A5 || s_wstrb !== 4'b0011) begin
                failures++;
                $display("FAIL write_fields[%0d]: s_valid=%b addr=%h wdata=%h wstrb=%b, required 1 00002004 a5a5a5a5 0011",
                         i, s_valid, s_addr, s_wdata, s_wstrb);
            end
        end
        wait_ready(5, got_m, got_d, got_to, lat);
        m1_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (got_m !== e.m || got_to !== e.tmo || (e.chk_d && got_d !== e.d)) begin
            failures++;
            $display("FAIL write_resp: master %0d timeout %b, required %0d %b", got_m, got_to, e.m, e.tmo);
        end
        @(negedge clk);
        checks++;
        if (m1_ready) begin
            failures++;
            $display("FAIL write_single_pulse: m1_ready=%b, required 0", m1_ready);
        end
    endtask

    task automatic test_timeout();
        int got_m, lat;
        logic [31:0] got_d;
        logic got_to;
        exp_t e;
        slave_mode = 0;
        e.m = 0; e.d = 32'hDEADBEEF; e.tmo = 1'b1; e.chk_d = 1'b1;
        sb.push_back(e);
        m0_valid = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'h0;
        wait_ready(30, got_m, got_d, got_to, lat);
        m0_valid = 1'b0;
        slave_mode = 2;
        e = sb.pop_front();
        checks++;
        if (got_m !== e.m || got_d !== e.d || got_to !== e.tmo) begin
            failures++;
            $display("FAIL timeout_resp: master %0d rdata %h timeout %b, required %0d %h %b",
                     got_m, got_d, got_to, e.m, e.d, e.tmo);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles after valid, required 17", lat);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (m0_ready || m1_ready || timeout || s_valid || busy) begin
                failures++;
                $display("FAIL late_s_ready: m0_ready=%b m1_ready=%b timeout=%b s_valid=%b busy=%b, required all 0",
                         m0_ready, m1_ready, timeout, s_valid, busy);
            end
        end
        slave_mode = 1;
        repeat (2) @(negedge clk);
    endtask

    // s_ready lands exactly on the terminal-count cycle.
    task automatic test_race();
        int got_m, lat;
        logic [31:0] got_d;
        logic got_to;
        exp_t e;
        slave_mode = 1; slave_wait = 15; use_fixed = 1'b1; fixed_data = 32'hCAFEF00D;
        e.m = 0; e.d = 32'hCAFEF00D; e.tmo = 1'b0; e.chk_d = 1'b1;
        sb.push_back(e);
        m0_valid = 1'b1; m0_addr = 32'h400;
        wait_ready(30, got_m, got_d, got_to, lat);
        m0_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (got_m !== e.m || got_d !== e.d || got_to !== e.tmo) begin
            failures++;
            $display("FAIL race_resp: master %0d rdata %h timeout %b, required %0d %h %b",
                     got_m, got_d, got_to, e.m, e.d, e.tmo);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL race_latency: got %0d cycles, required 17", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int got_m, lat;
        logic [31:0] got_d;
        logic got_to;
        exp_t e;
        slave_mode = 0;
        m0_valid = 1'b1; m0_addr = 32'h500;
        repeat (3) @(negedge clk);
        checks++;
        if (!busy || !s_valid) begin
            failures++;
            $display("FAIL midreset_busy: busy=%b s_valid=%b, required 1 1", busy, s_valid);
        end
        rst = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h600; m1_wstrb = 4'h0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata,
                 timeout, busy} !== '0) begin
                failures++;
                $display("FAIL midreset_outputs[%0d]: s_valid=%b s_addr=%h m0_ready=%b m1_ready=%b busy=%b, required all 0",
                         i, s_valid, s_addr, m0_ready, m1_ready, busy);
            end
            @(negedge clk);
        end
        slave_mode = 1; slave_wait = 1; use_fixed = 1'b0;
        e.tmo = 1'b0; e.chk_d = 1'b1;
        e.m = 0; e.d = 32'h500 ^ 32'hC0DE0000; sb.push_back(e);
        e.m = 1; e.d = 32'h600 ^ 32'hC0DE0000; sb.push_back(e);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_ready(10, got_m, got_d, got_to, lat);
            if (i == 0) m0_valid = 1'b0;
            else        m1_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (got_m !== e.m || got_d !== e.d || got_to !== e.tmo) begin
                failures++;
                $display("FAIL post_reset_tie[%0d]: master %0d rdata %h timeout %b, required %0d %h %b",
                         i, got_m, got_d, got_to, e.m, e.d, e.tmo);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_read();
        test_write();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
